// File: rtl/riscv_defines.sv
// Shared types for the register-file write-back port arbiter.
// Optional DIFT tag bit in the write-back payload: WB_ARB_DIFT_EN.
package riscv_defines;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned WB_DATA_W = 32;

    // Which producer owns the write port in a given cycle
    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_EX   = 2'd1,
        WB_SRC_LSU  = 2'd2
    } wb_src_e;

    // One register-file write: destination, data and optional taint tag
    typedef struct packed {
        logic [WB_ADDR_W-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
`ifdef WB_ARB_DIFT_EN
        logic                 tag;
`endif
    } wb_entry_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// Small synchronous FIFO of write-back entries with push/pop/flush and occupancy.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module riscv_wb_fifo
    import riscv_defines::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  wb_entry_t     din_i,
    input  logic          pop_i,
    output wb_entry_t     dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Requests are qualified here as well so the FIFO can never over/underflow
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    // Next pointers, occupancy and storage contents
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/riscv_wb_port_arbiter.sv
// Shares register-file write port A between buffered EX results and LSU load data.
// LSU wins by default; after STARVE_MAX consecutive LSU wins over a waiting EX
// entry, EX is forced through for one cycle.
// Optional DIFT tag ports and storage: WB_ARB_DIFT_EN.
module riscv_wb_port_arbiter
    import riscv_defines::*;
#(
    parameter  int unsigned FIFO_DEPTH = 2,
    parameter  int unsigned STARVE_MAX = 3,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned STARVE_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [4:0]       ex_waddr_i,
    input  logic [31:0]      ex_wdata_i,
`ifdef WB_ARB_DIFT_EN
    input  logic             ex_wtag_i,
    input  logic             lsu_wtag_i,
    output logic             rf_wtag_o,
`endif
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [4:0]       lsu_waddr_i,
    input  logic [31:0]      lsu_wdata_i,
    input  logic             flush_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic [CNT_W-1:0] fifo_count_o
);

    wb_entry_t           ex_entry;
    wb_entry_t           lsu_entry;
    wb_entry_t           fifo_head;
    wb_entry_t           rf_entry_q, rf_entry_d;
    logic                rf_we_q, rf_we_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_nonempty;
    logic                ex_push;
    logic                starve_hit;
    logic                grant_lsu;
    logic                grant_ex;
    wb_src_e             src;

    // Full means no push, even if the head pops in the same cycle
    assign ex_ready_o    = ~fifo_full & ~flush_i;
    // Writes to x0 are acknowledged but never occupy a slot
    assign ex_push       = ex_valid_i & ex_ready_o & (ex_waddr_i != '0);
    assign fifo_nonempty = ~fifo_empty;

    // Pack the producer payloads
    always_comb begin
        ex_entry        = '0;
        ex_entry.waddr  = ex_waddr_i;
        ex_entry.wdata  = ex_wdata_i;
        lsu_entry       = '0;
        lsu_entry.waddr = lsu_waddr_i;
        lsu_entry.wdata = lsu_wdata_i;
`ifdef WB_ARB_DIFT_EN
        ex_entry.tag    = ex_wtag_i;
        lsu_entry.tag   = lsu_wtag_i;
`endif
    end

    riscv_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ex_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (ex_push),
        .din_i   (ex_entry),
        .pop_i   (grant_ex),
        .dout_o  (fifo_head),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Arbitration: LSU first unless a waiting EX entry has been starved too long
    always_comb begin
        starve_hit = (starve_q == STARVE_W'(STARVE_MAX));
        grant_lsu  = lsu_valid_i & ~(fifo_nonempty & starve_hit & ~flush_i);
        grant_ex   = fifo_nonempty & ~grant_lsu & ~flush_i;
        src        = WB_SRC_NONE;
        if (grant_lsu) begin
            src = WB_SRC_LSU;
        end else if (grant_ex) begin
            src = WB_SRC_EX;
        end
    end

    assign lsu_ready_o = grant_lsu;

    // Starve counter and write-port register next state
    always_comb begin
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_entry_d = rf_entry_q;
        if (flush_i || grant_ex || !fifo_nonempty) begin
            starve_d = '0;
        end else if (grant_lsu && !starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        unique case (src)
            WB_SRC_LSU: begin
                rf_we_d    = 1'b1;
                rf_entry_d = lsu_entry;
            end
            WB_SRC_EX: begin
                rf_we_d    = 1'b1;
                rf_entry_d = fifo_head;
            end
            default: begin
                rf_we_d    = 1'b0;
            end
        endcase
    end

    // Registered write port and starve counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_entry_q <= '0;
            starve_q   <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_entry_q <= rf_entry_d;
            starve_q   <= starve_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_entry_q.waddr;
    assign rf_wdata_o = rf_entry_q.wdata;
`ifdef WB_ARB_DIFT_EN
    assign rf_wtag_o  = rf_entry_q.tag;
`endif

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// Self-checking bench for riscv_wb_port_arbiter (FIFO_DEPTH=2, STARVE_MAX=3).
module tb_riscv_wb_port_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned SMAX  = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid_i;
    logic          ex_ready_o;
    logic [4:0]    ex_waddr_i;
    logic [31:0]   ex_wdata_i;
    logic          lsu_valid_i;
    logic          lsu_ready_o;
    logic [4:0]    lsu_waddr_i;
    logic [31:0]   lsu_wdata_i;
    logic          flush_i;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [31:0]   rf_wdata_o;
    logic [CW-1:0] fifo_count_o;
`ifdef WB_ARB_DIFT_EN
    logic          ex_wtag_i  = 1'b0;
    logic          lsu_wtag_i = 1'b0;
    logic          rf_wtag_o;
`endif

    always #5 clk = ~clk;

    riscv_wb_port_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_waddr_i   (ex_waddr_i),
        .ex_wdata_i   (ex_wdata_i),
`ifdef WB_ARB_DIFT_EN
        .ex_wtag_i    (ex_wtag_i),
        .lsu_wtag_i   (lsu_wtag_i),
        .rf_wtag_o    (rf_wtag_o),
`endif
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .flush_i      (flush_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .fifo_count_o (fifo_count_o)
    );

    typedef struct {
        logic        exv;
        logic [4:0]  exa;
        logic [31:0] exd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        fl;
        logic        rdy_l;
        logic        rdy_e;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        int          cnt;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        m_fifo[$];
    ent_t        sb[$];
    int          m_starve = 0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    logic        m_last_glsu = 1'b0;
    vec_t        tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic exv, input logic [4:0] exa, input logic [31:0] exd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic fl, input logic rl, input logic re,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input int cnt);
        vec_t v;
        v.exv = exv; v.exa = exa; v.exd = exd;
        v.lv = lv; v.la = la; v.ld = ld; v.fl = fl;
        v.rdy_l = rl; v.rdy_e = re; v.we = we; v.wa = wa; v.wd = wd; v.cnt = cnt;
        return v;
    endfunction

    // Idle inputs with the given expected outputs
    function automatic vec_t idl(input logic rl, input logic re, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd, input int cnt);
        return mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, rl, re, we, wa, wd, cnt);
    endfunction

    // Compare the registered write port against the scoreboard
    task automatic check_out();
        ent_t e;
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            m_wa = e.a;
            m_wd = e.d;
            chk("rf_we", 32'(rf_we_o), 32'd1);
        end else begin
            chk("rf_we", 32'(rf_we_o), 32'd0);
        end
        chk("rf_waddr", 32'(rf_waddr_o), 32'(m_wa));
        chk("rf_wdata", rf_wdata_o, m_wd);
    endtask

    // Apply one cycle of stimulus (called at posedge+1), check, and advance the model
    task automatic run_vec(input vec_t v, input bit tbl_chk);
        logic m_ne, e_rdy_e, e_gl, e_ge, e_push;
        ent_t e;
        ex_valid_i  = v.exv;
        ex_waddr_i  = v.exa;
        ex_wdata_i  = v.exd;
        lsu_valid_i = v.lv;
        lsu_waddr_i = v.la;
        lsu_wdata_i = v.ld;
        flush_i     = v.fl;
        #2;
        m_ne    = (m_fifo.size() != 0);
        e_rdy_e = (m_fifo.size() < int'(DEPTH)) && !v.fl;
        e_gl    = v.lv && !(m_ne && (m_starve == int'(SMAX)) && !v.fl);
        e_ge    = m_ne && !e_gl && !v.fl;
        e_push  = v.exv && e_rdy_e && (v.exa != 5'd0);
        chk("lsu_ready", 32'(lsu_ready_o), 32'(e_gl));
        chk("ex_ready", 32'(ex_ready_o), 32'(e_rdy_e));
        if (tbl_chk) begin
            chk("tbl_lsu_ready", 32'(lsu_ready_o), 32'(v.rdy_l));
            chk("tbl_ex_ready", 32'(ex_ready_o), 32'(v.rdy_e));
        end
        if (e_gl) begin
            e.a = v.la;
            e.d = v.ld;
            sb.push_back(e);
        end else if (e_ge) begin
            sb.push_back(m_fifo[0]);
        end
        if (v.fl) begin
            m_fifo.delete();
        end else begin
            if (e_ge) void'(m_fifo.pop_front());
            if (e_push) begin
                e.a = v.exa;
                e.d = v.exd;
                m_fifo.push_back(e);
            end
        end
        if (v.fl || e_ge || !m_ne) m_starve = 0;
        else if (e_gl && m_starve < int'(SMAX)) m_starve++;
        m_last_glsu = e_gl;
        @(posedge clk);
        #1;
        check_out();
        chk("fifo_count", 32'(fifo_count_o), 32'(m_fifo.size()));
        if (tbl_chk) begin
            chk("tbl_rf_we", 32'(rf_we_o), 32'(v.we));
            chk("tbl_rf_waddr", 32'(rf_waddr_o), 32'(v.wa));
            chk("tbl_rf_wdata", rf_wdata_o, v.wd);
            chk("tbl_fifo_count", 32'(fifo_count_o), 32'(v.cnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        logic pend;
        logic [4:0]  pa;
        logic [31:0] pd;

        rst_n = 1'b0; ex_valid_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rf_we", 32'(rf_we_o), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("reset_rf_wdata", rf_wdata_o, 32'd0);
        chk("reset_fifo_count", 32'(fifo_count_o), 32'd0);
        rst_n = 1'b1;

        // EX only: push at N, write visible after the second edge
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1));
        tbl.push_back(idl(0, 1, 1, 5, 32'hDEADBEEF, 0));
        tbl.push_back(idl(0, 1, 0, 5, 32'hDEADBEEF, 0));
        // LSU and buffered EX together: LSU first, EX next
        tbl.push_back(mk(1, 3, 32'h33, 0, 0, 0, 0, 0, 1, 0, 5, 32'hDEADBEEF, 1));
        tbl.push_back(mk(0, 0, 0, 1, 7, 32'h1234, 0, 1, 1, 1, 7, 32'h1234, 1));
        tbl.push_back(idl(0, 1, 1, 3, 32'h33, 0));
        tbl.push_back(idl(0, 1, 0, 3, 32'h33, 0));
        // Starvation: three LSU wins, forced EX, LSU retried
        tbl.push_back(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 0, 3, 32'h33, 1));
        tbl.push_back(mk(0, 0, 0, 1, 10, 32'hA0, 0, 1, 1, 1, 10, 32'hA0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 11, 32'hA1, 0, 1, 1, 1, 11, 32'hA1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 12, 32'hA2, 0, 1, 1, 1, 12, 32'hA2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 13, 32'hA3, 0, 0, 1, 1, 9, 32'h99, 0));
        tbl.push_back(mk(0, 0, 0, 1, 13, 32'hA3, 0, 1, 1, 1, 13, 32'hA3, 0));
        tbl.push_back(idl(0, 1, 0, 13, 32'hA3, 0));
        // Full FIFO under continuous LSU traffic; third push waits for a pop
        tbl.push_back(mk(1, 1, 32'h11, 1, 20, 32'hB0, 0, 1, 1, 1, 20, 32'hB0, 1));
        tbl.push_back(mk(1, 2, 32'h22, 1, 21, 32'hB1, 0, 1, 1, 1, 21, 32'hB1, 2));
        tbl.push_back(mk(1, 4, 32'h44, 1, 22, 32'hB2, 0, 1, 0, 1, 22, 32'hB2, 2));
        tbl.push_back(mk(1, 4, 32'h44, 1, 23, 32'hB3, 0, 1, 0, 1, 23, 32'hB3, 2));
        tbl.push_back(mk(1, 4, 32'h44, 1, 24, 32'hB4, 0, 0, 0, 1, 1, 32'h11, 1));
        tbl.push_back(mk(1, 4, 32'h44, 1, 24, 32'hB4, 0, 1, 1, 1, 24, 32'hB4, 2));
        tbl.push_back(idl(0, 0, 1, 2, 32'h22, 1));
        tbl.push_back(idl(0, 1, 1, 4, 32'h44, 0));
        tbl.push_back(idl(0, 1, 0, 4, 32'h44, 0));
        // x0 destination: accepted, never stored or written
        tbl.push_back(mk(1, 0, 32'hFFFF, 0, 0, 0, 0, 0, 1, 0, 4, 32'h44, 0));
        tbl.push_back(idl(0, 1, 0, 4, 32'h44, 0));
        // Flush with two buffered entries, a blocked push and a concurrent LSU write
        tbl.push_back(mk(1, 6, 32'h66, 1, 25, 32'hC0, 0, 1, 1, 1, 25, 32'hC0, 1));
        tbl.push_back(mk(1, 8, 32'h88, 1, 26, 32'hC1, 0, 1, 1, 1, 26, 32'hC1, 2));
        tbl.push_back(mk(1, 15, 32'hF5, 1, 27, 32'hC2, 1, 1, 0, 1, 27, 32'hC2, 0));
        tbl.push_back(idl(0, 1, 0, 27, 32'hC2, 0));
        tbl.push_back(idl(0, 1, 0, 27, 32'hC2, 0));

        foreach (tbl[i]) run_vec(tbl[i], 1'b1);

        // Mid-operation reset with a write registered and one entry buffered
        run_vec(mk(1, 1, 32'h101, 0, 0, 0, 0, 0, 1, 0, 27, 32'hC2, 1), 1'b1);
        run_vec(mk(1, 2, 32'h202, 0, 0, 0, 0, 0, 1, 1, 1, 32'h101, 1), 1'b1);
        ex_valid_i = 1'b0; lsu_valid_i = 1'b0; flush_i = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_pre_edge_rf_we", 32'(rf_we_o), 32'd1);
        chk("rst_pre_edge_count", 32'(fifo_count_o), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count_o), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_rf_wdata", rf_wdata_o, 32'd0);
        m_fifo.delete();
        sb.delete();
        m_starve = 0;
        m_wa = '0;
        m_wd = '0;
        rst_n = 1'b1;
        run_vec(idl(0, 1, 0, 0, 32'h0, 0), 1'b1);
        run_vec(idl(0, 1, 0, 0, 32'h0, 0), 1'b1);

        // Random traffic against the reference model; refused LSU requests are held
        pend = 1'b0;
        pa = '0;
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            rv = idl(0, 0, 0, 0, 32'h0, 0);
            rv.exv = 1'($urandom_range(0, 1));
            rv.exa = 5'($urandom_range(0, 31));
            rv.exd = $urandom;
            if (pend) begin
                rv.lv = 1'b1;
                rv.la = pa;
                rv.ld = pd;
            end else begin
                rv.lv = ($urandom_range(0, 3) != 0);
                rv.la = 5'($urandom_range(0, 31));
                rv.ld = $urandom;
            end
            rv.fl = ($urandom_range(0, 15) == 0);
            run_vec(rv, 1'b0);
            pend = rv.lv && !m_last_glsu;
            pa = rv.la;
            pd = rv.ld;
        end
        run_vec(idl(0, 1, 0, 0, 32'h0, 0), 1'b0);
        run_vec(idl(0, 1, 0, 0, 32'h0, 0), 1'b0);
        run_vec(idl(0, 1, 0, 0, 32'h0, 0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_wb_port_arbiter.md
Name: riscv_wb_port_arbiter

Overview:
- Shares the single register-file write port between two producers: EX-stage results (ALU/MULT/CSR) and LSU load data.
- EX results are buffered in a small FIFO.
- LSU has priority, because load data cannot be held, subject to an anti-starvation limit that guarantees EX progress.
- Sits between the EX/LSU stages and the register file write port A.

Parameters:
- FIFO_DEPTH, 2: EX result buffer entries; power of two, >=2.
- STARVE_MAX, 3: consecutive LSU grants with a non-empty FIFO before EX is forced to win.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ex_valid_i  in  1  EX result valid
- ex_ready_o  out  1  FIFO can accept
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  32  EX result
- lsu_valid_i  in  1  load data valid
- lsu_ready_o  out  1  load granted this cycle
- lsu_waddr_i  in  5  load destination
- lsu_wdata_i  in  32  load data
- flush_i  in  1  drop all buffered EX entries
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Interface (already decided): one clock clk; reset rst_n is synchronous, active-low, sampled on posedge clk only.
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, fifo_count_o=0, starve counter=0, FIFO pointers=0.
- ex_ready_o = (count < FIFO_DEPTH) & ~flush_i. No push-through when full, even if a pop occurs that cycle.
- Push: when ex_valid_i & ex_ready_o. If ex_waddr_i==0 the result is accepted but not stored (count unchanged).
- Arbitration, combinational each cycle:
  - grant_lsu = lsu_valid_i & ~(fifo_nonempty & starve==STARVE_MAX & ~flush_i).
  - grant_ex = fifo_nonempty & ~grant_lsu & ~flush_i.
- lsu_ready_o = grant_lsu. It is combinational, so LSU sees the grant in the same cycle.
- Output register: on the cycle after a grant, rf_we_o=1 with the granted waddr/wdata. If there was no grant, rf_we_o=0 and rf_waddr_o/rf_wdata_o hold their previous values.
- Latency:
  - LSU: valid at cycle N -> rf write at N+1.
  - EX: push at N -> earliest grant at N+1 -> rf write at N+2.
- Pop occurs on grant_ex.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - +1 when grant_lsu & fifo_nonempty, saturating at STARVE_MAX.
  - Cleared to 0 on grant_ex or when the FIFO is empty.
- Forced EX (starve==STARVE_MAX): lsu_ready_o=0 while lsu_valid_i=1. LSU must hold its request; it is granted the following cycle.
- flush_i:
  - Count and pointers go to 0 at the next edge; any push that cycle is blocked; no EX grant that cycle.
  - An LSU grant that cycle proceeds normally; starve counter is cleared.
  - An output write already registered is not cancelled.
- Mid-operation reset: FIFO contents are discarded and rf_we_o is deasserted at the next edge.

Optional Feature:
- Macro: WB_ARB_DIFT_EN.
- Defined:
  - Adds ex_wtag_i (in, 1), lsu_wtag_i (in, 1) and rf_wtag_o (out, 1).
  - The tag is stored in the FIFO alongside the data and follows the same grant/latency as rf_wdata_o.
  - rf_wtag_o resets to 0.
- Undefined: the ports and tag storage are absent; behaviour is otherwise identical.

Decomposition:
- riscv_defines package:
  - Source select enum WB_SRC_NONE/WB_SRC_EX/WB_SRC_LSU.
  - Packed struct wb_entry_t {waddr[4:0], wdata[31:0], tag under WB_ARB_DIFT_EN}.
- One sub-module, riscv_wb_fifo: generic synchronous FIFO of wb_entry_t with push/pop/flush/count.
- Arbitration, starve counter and output register stay in the top module.

Test Plan:
- EX only: push x5=0xDEADBEEF at cycle 1 -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF at cycle 3; fifo_count_o returns to 0.
- Simultaneous: FIFO holds x3; lsu_valid_i (x7=0x1234) at the same cycle -> lsu_ready_o=1; x7 written next cycle, x3 the cycle after.
- Starvation: FIFO non-empty with lsu_valid_i held high for 5 cycles -> 3 LSU grants, then lsu_ready_o=0 for one cycle and EX is written, then LSU resumes.
- Full: DEPTH=2 with two pushes and LSU continuously valid -> ex_ready_o=0, count=2; a third push is refused until the first EX pop.
- flush_i with count=2 and a concurrent push -> count=0 next cycle, no EX writes afterwards, concurrent LSU write still occurs.
- Reset asserted with rf_we_o=1 and count=1 -> next edge rf_we_o=0, count=0; no glitch before the edge (synchronous reset).
